pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_frame_timer.sv | 46 ++++
 rtl/pong_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and datapath widths for the pong game controller
package pong_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int STEP_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_MISS   = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } state_e;

endpackage

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - once-per-frame tick from the sync counters plus the serve frame countdown
module pong_frame_timer
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int FRAME_Y      = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic [X_W-1:0] counter_x,
    input  logic [Y_W-1:0] counter_y,
    output logic           frame_tick,
    output logic           serve_done
);

    localparam int CNT_W = $clog2(SERVE_FRAMES) + 1;

    logic             frame_tick_q;
    logic [CNT_W-1:0] serve_cnt_q;
    logic [CNT_W-1:0] serve_cnt_d;

    always_comb begin
        serve_cnt_d = serve_cnt_q;
        if (clear) begin
            serve_cnt_d = '0;
        end else if (frame_tick_q) begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_q <= 1'b0;
            serve_cnt_q  <= '0;
        end else begin
            frame_tick_q <= (counter_x == '0) && (counter_y == Y_W'(FRAME_Y));
            serve_cnt_q  <= serve_cnt_d;
        end
    end

    // Done only on the tick that completes the last held frame.
    assign serve_done = frame_tick_q && (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1));
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game FSM driving ball reload, speed, score and lives.
// Define PONG_PAUSE_EN to add the pause input and the PAUSED state.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_Y       = 464,
    parameter int SPEEDUP_HITS = 8,
    parameter int MAX_SPEED    = 4,
    parameter int SERVE_X      = 320,
    parameter int SERVE_Y      = 64,
    parameter int FRAME_Y      = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [X_W-1:0]    counter_x,
    input  logic [Y_W-1:0]    counter_y,
    input  logic              start,
    input  logic [Y_W-1:0]    ball_y,
    input  logic              paddle_hit,
`ifdef PONG_PAUSE_EN
    input  logic              pause,
`endif
    output logic              frame_tick,
    output logic              ball_load,
    output logic [X_W-1:0]    ball_load_x,
    output logic [Y_W-1:0]    ball_load_y,
    output logic [STEP_W-1:0] ball_step,
    output logic [7:0]        score,
    output logic [1:0]        lives,
    output logic              game_over,
    output logic [2:0]        state
);

    localparam int HIT_W = $clog2(SPEEDUP_HITS) + 1;

    state_e            state_q;
    logic [1:0]        lives_q;
    logic [7:0]        score_q;
    logic [STEP_W-1:0] speed_q;
    logic [HIT_W-1:0]  hit_cnt_q;
    logic              ball_load_q;
    logic [STEP_W-1:0] ball_step_q;
    logic              game_over_q;

    logic              serve_done;
    logic              speed_wrap;
    logic [STEP_W-1:0] speed_inc;

    pong_frame_timer #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .FRAME_Y      (FRAME_Y)
    ) u_frame_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q != ST_SERVE),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .frame_tick (frame_tick),
        .serve_done (serve_done)
    );

    assign speed_wrap = (hit_cnt_q == HIT_W'(SPEEDUP_HITS - 1));
    assign speed_inc  = (speed_q == STEP_W'(MAX_SPEED)) ? speed_q : speed_q + STEP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lives_q     <= 2'(LIVES);
            score_q     <= '0;
            speed_q     <= STEP_W'(1);
            hit_cnt_q   <= '0;
            ball_load_q <= 1'b0;
            ball_step_q <= '0;
            game_over_q <= 1'b0;
        end else begin
            ball_load_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_q     <= ST_SERVE;
                        lives_q     <= 2'(LIVES);
                        score_q     <= '0;
                        speed_q     <= STEP_W'(1);
                        hit_cnt_q   <= '0;
                        ball_load_q <= 1'b1;
                        ball_step_q <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (serve_done) begin
                        state_q     <= ST_PLAY;
                        ball_step_q <= speed_q;
                    end
                end
                ST_PLAY: begin
                    ball_step_q <= speed_q;
                    if (paddle_hit) begin
                        if (score_q != 8'hFF) begin
                            score_q <= score_q + 8'd1;
                        end
                        if (speed_wrap) begin
                            hit_cnt_q   <= '0;
                            speed_q     <= speed_inc;
                            ball_step_q <= speed_inc;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + HIT_W'(1);
                        end
                    end
                    // A miss wins over a same-cycle hit; the hit still scores above.
                    if (frame_tick && (ball_y >= Y_W'(MISS_Y))) begin
                        state_q     <= ST_MISS;
                        ball_step_q <= '0;
                    end
`ifdef PONG_PAUSE_EN
                    else if (pause) begin
                        state_q     <= ST_PAUSED;
                        ball_step_q <= '0;
                    end
`endif
                end
                ST_MISS: begin
                    lives_q     <= lives_q - 2'd1;
                    speed_q     <= STEP_W'(1);
                    hit_cnt_q   <= '0;
                    ball_step_q <= '0;
                    if (lives_q == 2'd1) begin
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q     <= ST_SERVE;
                        ball_load_q <= 1'b1;
                    end
                end
`ifdef PONG_PAUSE_EN
                ST_PAUSED: begin
                    if (pause) begin
                        state_q     <= ST_PLAY;
                        ball_step_q <= speed_q;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    ball_step_q <= '0;
                end
            endcase
        end
    end

    assign ball_load   = ball_load_q;
    assign ball_load_x = X_W'(SERVE_X);
    assign ball_load_y = Y_W'(SERVE_Y);
    assign ball_step   = ball_step_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized self-checking bench for pong_game_ctrl against an event-level game model
module tb_pong_game_ctrl;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 2;
    localparam int MISS_Y       = 464;
    localparam int SPEEDUP_HITS = 8;
    localparam int MAX_SPEED    = 4;
    localparam int SERVE_X      = 320;
    localparam int SERVE_Y      = 64;
    localparam int FRAME_Y      = 500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] counter_x = '0;
    logic [8:0] counter_y = '0;
    logic       start = 1'b0;
    logic [8:0] ball_y = '0;
    logic       paddle_hit = 1'b0;
`ifdef PONG_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       frame_tick;
    logic       ball_load;
    logic [9:0] ball_load_x;
    logic [8:0] ball_load_y;
    logic [2:0] ball_step;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;

    pong_game_ctrl #(
        .LIVES        (LIVES),
        .SERVE_FRAMES (SERVE_FRAMES),
        .MISS_Y       (MISS_Y),
        .SPEEDUP_HITS (SPEEDUP_HITS),
        .MAX_SPEED    (MAX_SPEED),
        .SERVE_X      (SERVE_X),
        .SERVE_Y      (SERVE_Y),
        .FRAME_Y      (FRAME_Y)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .start       (start),
        .ball_y      (ball_y),
        .paddle_hit  (paddle_hit),
`ifdef PONG_PAUSE_EN
        .pause       (pause),
`endif
        .frame_tick  (frame_tick),
        .ball_load   (ball_load),
        .ball_load_x (ball_load_x),
        .ball_load_y (ball_load_y),
        .ball_step   (ball_step),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over),
        .state       (state)
    );

    always #20 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Game model: 0 idle, 1 serve, 2 play, 4 over, 5 paused; MISS is folded into the frame event.
    int m_state, m_lives, m_score, m_hits, m_ticks;
    int m_loads = 0;

    int         load_cnt = 0;
    logic [9:0] last_lx = '0;
    logic [8:0] last_ly = '0;

    always @(negedge clk) begin
        if (ball_load === 1'b1) begin
            load_cnt <= load_cnt + 1;
            last_lx  <= ball_load_x;
            last_ly  <= ball_load_y;
        end
    end

    function automatic int exp_step();
        int s;
        if (m_state != 2) return 0;
        s = 1 + m_hits / SPEEDUP_HITS;
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_score = 0; m_hits = 0; m_ticks = 0;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 4) begin
            m_lives = LIVES; m_score = 0; m_hits = 0; m_ticks = 0; m_state = 1; m_loads++;
        end
    endtask

    task automatic model_hit();
        if (m_state == 2) begin
            if (m_score < 255) m_score++;
            m_hits++;
        end
    endtask

    task automatic model_frame(input int y);
        if (m_state == 1) begin
            m_ticks++;
            if (m_ticks == SERVE_FRAMES) m_state = 2;
        end else if (m_state == 2 && y >= MISS_Y) begin
            m_lives--;
            m_hits = 0;
            if (m_lives == 0) m_state = 4;
            else begin m_state = 1; m_ticks = 0; m_loads++; end
        end
    endtask

    task automatic cyc(input bit fr, input bit hit, input bit st);
        counter_x  = fr ? 10'd0 : 10'($urandom_range(1, 799));
        counter_y  = fr ? 9'(FRAME_Y) : 9'($urandom_range(0, 511));
        paddle_hit = hit;
        start      = st;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic ev_start();
        cyc(1'b0, 1'b0, 1'b1); model_start(); idle(3);
    endtask

    task automatic ev_hits(input int n);
        for (int i = 0; i < n; i++) begin cyc(1'b0, 1'b1, 1'b0); model_hit(); end
        idle(2);
    endtask

    task automatic ev_frame(input int y, input bit hit_same);
        ball_y = 9'(y);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, hit_same, 1'b0);
        if (hit_same) model_hit();
        model_frame(y);
        idle(3);
        ball_y = 9'($urandom_range(0, MISS_Y - 1));
    endtask

    task automatic to_play();
        for (int i = 0; i < SERVE_FRAMES; i++) ev_frame($urandom_range(0, MISS_Y - 1), 1'b0);
    endtask

`ifdef PONG_PAUSE_EN
    task automatic ev_pause();
        pause = 1'b1; cyc(1'b0, 1'b0, 1'b0); pause = 1'b0;
        if (m_state == 2) m_state = 5; else if (m_state == 5) m_state = 2;
        idle(2);
    endtask
`endif

    task automatic test_reset();
        rst_n = 1'b0; idle(2); model_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        checks++; if (ball_load !== 1'b0) begin errors++; $display("FAIL reset_ball_load got=%b exp=0", ball_load); end
        checks++; if (ball_step !== 3'd0) begin errors++; $display("FAIL reset_ball_step got=%0d exp=0", ball_step); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (lives !== 2'(LIVES)) begin errors++; $display("FAIL reset_lives got=%0d exp=%0d", lives, LIVES); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        rst_n = 1'b1; idle(2);
    endtask

    task automatic test_frame_tick();
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_high got=%b exp=1", frame_tick); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle got=%b exp=0", frame_tick); end
        counter_x = 10'd1; counter_y = 9'(FRAME_Y); @(posedge clk); #1;
        idle(1);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_x1_no_tick got=%b exp=0", frame_tick); end
        checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL tick_idle_state got=%0d exp=%0d", state, m_state); end
    endtask

    task automatic test_serve();
        ev_hits(2);
        ev_start();
        checks++; if (load_cnt !== m_loads) begin errors++; $display("FAIL serve_load_cnt got=%0d exp=%0d", load_cnt, m_loads); end
        checks++; if (last_lx !== 10'(SERVE_X) || last_ly !== 9'(SERVE_Y)) begin errors++; $display("FAIL serve_load_xy got=%0d,%0d exp=%0d,%0d", last_lx, last_ly, SERVE_X, SERVE_Y); end
        ev_hits(3);
        checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL serve_hit_ignored got=%0d exp=%0d", score, m_score); end
        for (int i = 0; i < SERVE_FRAMES; i++) begin
            checks++; if (state !== 3'(m_state) || ball_step !== 3'(exp_step())) begin errors++; $display("FAIL serve_frame%0d got=%0d/%0d exp=%0d/%0d", i, state, ball_step, m_state, exp_step()); end
            ev_frame($urandom_range(0, MISS_Y - 1), 1'b0);
        end
        checks++; if (state !== 3'(m_state) || ball_step !== 3'(exp_step())) begin errors++; $display("FAIL serve_to_play got=%0d/%0d exp=%0d/%0d", state, ball_step, m_state, exp_step()); end
    endtask

    task automatic test_miss();
        ev_hits($urandom_range(1, 6));
        ev_frame(470, 1'b0);
        checks++; if (lives !== 2'(m_lives)) begin errors++; $display("FAIL miss_lives got=%0d exp=%0d", lives, m_lives); end
        checks++; if (load_cnt !== m_loads) begin errors++; $display("FAIL miss_reload got=%0d exp=%0d", load_cnt, m_loads); end
        checks++; if (state !== 3'(m_state) || ball_step !== 3'(exp_step())) begin errors++; $display("FAIL miss_serve got=%0d/%0d exp=%0d/%0d", state, ball_step, m_state, exp_step()); end
        to_play();
        checks++; if (ball_step !== 3'(exp_step())) begin errors++; $display("FAIL miss_resume_step got=%0d exp=%0d", ball_step, exp_step()); end
    endtask

    task automatic test_start_ignored();
        ev_start();
        checks++; if (state !== 3'(m_state) || load_cnt !== m_loads) begin errors++; $display("FAIL start_in_play got=%0d/%0d exp=%0d/%0d", state, load_cnt, m_state, m_loads); end
    endtask

    task automatic test_hit_on_miss();
        ev_hits($urandom_range(1, 5));
        ev_frame($urandom_range(MISS_Y, 511), 1'b1);
        checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL hit_on_miss_score got=%0d exp=%0d", score, m_score); end
        checks++; if (state !== 3'(m_state) || lives !== 2'(m_lives)) begin errors++; $display("FAIL hit_on_miss_state got=%0d/%0d exp=%0d/%0d", state, lives, m_state, m_lives); end
    endtask

    task automatic test_speedup();
        to_play();
        ev_hits(8);
        checks++; if (ball_step !== 3'(exp_step())) begin errors++; $display("FAIL speed_8 got=%0d exp=%0d", ball_step, exp_step()); end
        ev_hits(24);
        checks++; if (ball_step !== 3'(exp_step())) begin errors++; $display("FAIL speed_32 got=%0d exp=%0d", ball_step, exp_step()); end
        while (m_hits < 280) begin
            ev_hits($urandom_range(1, 24));
            if ($urandom_range(0, 2) == 0) ev_frame($urandom_range(0, MISS_Y - 1), 1'b0);
            checks++; if (score !== 8'(m_score) || ball_step !== 3'(exp_step())) begin errors++; $display("FAIL speed_batch got=%0d/%0d exp=%0d/%0d", score, ball_step, m_score, exp_step()); end
        end
    endtask

    task automatic test_game_over();
        ev_frame($urandom_range(MISS_Y, 511), 1'b0);
        checks++; if (lives !== 2'(m_lives) || game_over !== 1'b1 || state !== 3'(m_state)) begin errors++; $display("FAIL over_enter got=%0d/%b/%0d exp=%0d/1/%0d", lives, game_over, state, m_lives, m_state); end
        checks++; if (ball_step !== 3'd0 || score !== 8'(m_score) || load_cnt !== m_loads) begin errors++; $display("FAIL over_hold got=%0d/%0d/%0d exp=0/%0d/%0d", ball_step, score, load_cnt, m_score, m_loads); end
        ev_hits(2);
        ev_frame($urandom_range(MISS_Y, 511), 1'b0);
        ev_start();
        checks++; if (lives !== 2'(m_lives) || score !== 8'(m_score) || state !== 3'(m_state) || game_over !== 1'b0) begin errors++; $display("FAIL over_restart got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/0", lives, score, state, game_over, m_lives, m_score, m_state); end
        checks++; if (load_cnt !== m_loads) begin errors++; $display("FAIL over_reload got=%0d exp=%0d", load_cnt, m_loads); end
    endtask

    task automatic test_reset_mid_play();
        to_play();
        ev_hits(17);
        checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL rst_pre_score got=%0d exp=%0d", score, m_score); end
        rst_n = 1'b0; #1;
        model_reset();
        checks++; if (score !== 8'd0 || lives !== 2'(LIVES) || state !== 3'd0 || ball_step !== 3'd0) begin errors++; $display("FAIL rst_async got=%0d/%0d/%0d/%0d exp=0/%0d/0/0", score, lives, state, ball_step, LIVES); end
        idle(2); rst_n = 1'b1;
        ev_frame($urandom_range(0, MISS_Y - 1), 1'b0);
        ev_frame($urandom_range(0, MISS_Y - 1), 1'b0);
        checks++; if (load_cnt !== m_loads || state !== 3'(m_state)) begin errors++; $display("FAIL rst_no_load got=%0d/%0d exp=%0d/%0d", load_cnt, state, m_loads, m_state); end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        ev_start(); to_play(); ev_hits(9);
        ev_pause();
        checks++; if (state !== 3'(m_state) || ball_step !== 3'd0) begin errors++; $display("FAIL pause_enter got=%0d/%0d exp=%0d/0", state, ball_step, m_state); end
        ev_hits(2);
        ev_frame($urandom_range(MISS_Y, 511), 1'b0);
        ev_start();
        checks++; if (score !== 8'(m_score) || lives !== 2'(m_lives) || state !== 3'(m_state)) begin errors++; $display("FAIL pause_ignore got=%0d/%0d/%0d exp=%0d/%0d/%0d", score, lives, state, m_score, m_lives, m_state); end
        ev_pause();
        checks++; if (state !== 3'(m_state) || ball_step !== 3'(exp_step())) begin errors++; $display("FAIL pause_resume got=%0d/%0d exp=%0d/%0d", state, ball_step, m_state, exp_step()); end
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ball_y = 9'd100;
        test_reset();
        test_frame_tick();
        test_serve();
        test_miss();
        test_start_ignored();
        test_hit_on_miss();
        test_speedup();
        test_game_over();
        test_reset_mid_play();
`ifdef PONG_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
